// File: rtl/imem_loader_if.sv
// Loader bus: byte-stream handshake in, instruction-memory init port and
// CPU status out. The loader uses the master view; the byte source / CPU
// side uses the slave view.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        initialize;
  logic [31:0] instruction_initialize_data;
  logic [31:0] instruction_initialize_address;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output initialize,
    output instruction_initialize_data,
    output instruction_initialize_address,
    output cpu_rst,
    output done,
    output error,
    output words_loaded
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  initialize,
    input  instruction_initialize_data,
    input  instruction_initialize_address,
    input  cpu_rst,
    input  done,
    input  error,
    input  words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: takes a byte stream (16-bit big-endian word count, then
// that many big-endian 32-bit words) and writes each word into instruction
// memory at consecutive word addresses, holding the CPU in reset until the
// image is complete.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

  state_t      r_state;
  state_t      w_state_next;

  // Only the three most recent bytes need keeping; the fourth arrives live.
  logic [23:0] r_word;
  logic [1:0]  r_byte_idx;
  logic [15:0] r_hdr_count;
  logic [15:0] r_words_loaded;
  logic [31:0] r_wr_data;
  logic [31:0] r_wr_addr;

  logic        w_in_ready;
  logic        w_accept;
  logic [31:0] w_word_next;
  logic [15:0] w_hdr_full;
  logic [16:0] w_words_inc;
  logic [31:0] w_wr_addr;
  logic        w_initialize;
  logic        w_cpu_rst;
  logic        w_done;
  logic        w_error;

  // Ready only in byte-consuming states, and never while reset is held.
  assign w_in_ready  = rst && ((r_state == S_HDR0) || (r_state == S_HDR1) ||
                               (r_state == S_LOAD));
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_word_next = {r_word, bus.in_data};
  // In HDR1 the header MSB is already the newest byte of the shift register.
  assign w_hdr_full  = w_word_next[15:0];
  assign w_words_inc = {1'b0, r_words_loaded} + 17'd1;
  // Byte address of the word about to be written; wraps at 32 bits.
  assign w_wr_addr   = BASE_ADDR + {14'd0, r_words_loaded, 2'b00};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_HDR0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    w_initialize = 1'b0;
    w_cpu_rst    = 1'b1;
    w_done       = 1'b0;
    w_error      = 1'b0;
    case (r_state)
      S_HDR0: begin
        if (w_accept) begin
          w_state_next = S_HDR1;
        end
      end
      S_HDR1: begin
        if (w_accept) begin
          if (w_hdr_full == 16'd0) begin
            w_state_next = S_DONE;
          end else if ({1'b0, w_hdr_full} > MAX_WORDS_W) begin
            w_state_next = S_ERROR;
          end else begin
            w_state_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_accept && (r_byte_idx == 2'd3)) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_initialize = 1'b1;
        if (w_words_inc < {1'b0, r_hdr_count}) begin
          w_state_next = S_LOAD;
        end else begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_cpu_rst = 1'b0;
        w_done    = 1'b1;
      end
      S_ERROR: begin
        w_error = 1'b1;
      end
      default: begin
        w_state_next = S_HDR0;
      end
    endcase
  end

  // Datapath: byte assembly, header capture, write-port registers, counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word         <= 24'd0;
      r_byte_idx     <= 2'd0;
      r_hdr_count    <= 16'd0;
      r_words_loaded <= 16'd0;
      r_wr_data      <= 32'd0;
      r_wr_addr      <= BASE_ADDR;
    end else begin
      if (w_accept) begin
        r_word <= w_word_next[23:0];
      end
      if (w_accept && (r_state == S_HDR1)) begin
        r_hdr_count <= w_hdr_full;
      end
      if (w_accept && (r_state == S_LOAD)) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        // Latch the completed word and its address for the WRITE cycle;
        // they then hold until the next word completes.
        if (r_byte_idx == 2'd3) begin
          r_wr_data <= w_word_next;
          r_wr_addr <= w_wr_addr;
        end
      end
      if (r_state == S_WRITE) begin
        r_words_loaded <= r_words_loaded + 16'd1;
      end
    end
  end

  assign bus.in_ready                       = w_in_ready;
  assign bus.initialize                     = w_initialize;
  assign bus.instruction_initialize_data    = r_wr_data;
  assign bus.instruction_initialize_address = r_wr_addr;
  assign bus.cpu_rst                        = w_cpu_rst;
  assign bus.done                           = w_done;
  assign bus.error                          = w_error;
  assign bus.words_loaded                   = r_words_loaded;

endmodule
